anc_coef_bank_ctrl: RTL and testbench

- Parametrised coefficient-bank controller for the ANC adaptive filter. Next generation of the single-channel coefficient RAM controller.
- Holds CHANNELS independent banks of TAPS coefficients in an internal synchronous-read memory.
- Each enabled filter pass sweeps one bank from tap TAPS-1 down to tap 0. For every tap it presents the stored coefficient to the LMS datapath, then writes back the updated value through a valid handshake.
- Adds read-only and bank-clear modes, channel selection, abort on enable drop, and a strict guard so that no address at or above TAPS is ever written.

---
 rtl/anc_coef_bank_ctrl.sv | 151 +++++++++++++++
 tb/tb_anc_coef_bank_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/anc_coef_bank_ctrl.sv
// anc_coef_bank_ctrl
// Coefficient-bank controller for the ANC adaptive LMS filter. Holds CHANNELS
// banks of TAPS coefficients in a synchronous-read memory and sweeps one bank
// per filter pass, tap TAPS-1 down to 0, in update, read-only or clear mode.
//
// Ports:
//   Clk_100M, Reset_n       clock, async active-low reset
//   FilterEN_In             pass enable; rising edge starts, low aborts
//   Chan_In, Mode_In        bank and mode, sampled on the start edge
//                           (00 update, 01/11 read-only, 10 clear)
//   Wz_In, WzIn_Valid       updated coefficient from the LMS datapath
//   WzOut, WzOut_Valid      stored coefficient presented for TapIdx
//   TapIdx                  tap being presented
//   Busy                    FSM not idle
//   FiltComplete            sweep finished normally (one cycle)
//   SweepAbort              sweep aborted by enable drop (one cycle)
//   ChanErr                 start rejected, channel out of range (one cycle)
//
// state | meaning
// IDLE  | waiting for a FilterEN_In rising edge
// RD    | read issued for the current tap
// PRES  | coefficient presented; update mode waits for WzIn_Valid
// CLR   | zero written to the current tap, one tap per cycle
// DONE  | FiltComplete high, returns to IDLE

module anc_coef_bank_ctrl #(
   parameter int COEF_W   = 11,
   parameter int TAPS     = 120,
   parameter int ADDR_W   = 7,
   parameter int CHANNELS = 2,
   parameter int CH_W     = 1
) (
   input  logic              Clk_100M,
   input  logic              Reset_n,
   input  logic              FilterEN_In,
   input  logic [CH_W-1:0]   Chan_In,
   input  logic [1:0]        Mode_In,
   input  logic [COEF_W-1:0] Wz_In,
   input  logic              WzIn_Valid,
   output logic [COEF_W-1:0] WzOut,
   output logic              WzOut_Valid,
   output logic [ADDR_W-1:0] TapIdx,
   output logic              Busy,
   output logic              FiltComplete,
   output logic              SweepAbort,
   output logic              ChanErr
);

   localparam int DEPTH  = CHANNELS * TAPS;
   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] TAP_MAX = ADDR_W'(TAPS - 1);
   localparam logic [1:0] MODE_CLR = 2'b10;

   typedef enum logic [2:0] {S_IDLE, S_RD, S_PRES, S_CLR, S_DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] tap;
   logic [CH_W-1:0]   chan_q;
   logic [1:0]        mode_q;
   logic              fen_old;
   logic [COEF_W-1:0] rd_data;
   logic [COEF_W-1:0] mem [DEPTH];

   logic              start;
   logic              chan_bad;
   logic              read_only;
   logic              tap_ok;
   logic              advance;
   logic              mem_we;
   logic [COEF_W-1:0] mem_wdata;
   logic [MEM_AW-1:0] mem_addr;

   assign start     = FilterEN_In & ~fen_old;
   assign chan_bad  = int'(Chan_In) >= CHANNELS;
   // Modes 01 and 11 are both read-only; clear never reaches PRES.
   assign read_only = mode_q[0];
   // Last-line guard: a miscounted tap must never spill into the next bank.
   assign tap_ok    = int'(tap) < TAPS;
   assign advance   = (state == S_CLR) |
                      ((state == S_PRES) & (read_only | WzIn_Valid));
   // The write is not gated by FilterEN_In, so a write qualified on the
   // abort edge still lands.
   assign mem_we    = tap_ok & ((state == S_CLR) |
                                ((state == S_PRES) & ~read_only & WzIn_Valid));
   assign mem_wdata = (state == S_CLR) ? '0 : Wz_In;
   assign mem_addr  = MEM_AW'(int'(chan_q) * TAPS + int'(tap));

   always_ff @(posedge Clk_100M) begin
      if (mem_we)
         mem[mem_addr] <= mem_wdata;
      if (state == S_RD)
         rd_data <= mem[mem_addr];
   end

   assign Busy         = (state != S_IDLE);
   assign WzOut_Valid  = (state == S_PRES);
   assign WzOut        = WzOut_Valid ? rd_data : '0;
   assign TapIdx       = WzOut_Valid ? tap : '0;
   assign FiltComplete = (state == S_DONE);

   always_ff @(posedge Clk_100M or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= S_IDLE;
         tap        <= TAP_MAX;
         chan_q     <= '0;
         mode_q     <= '0;
         fen_old    <= 1'b0;
         SweepAbort <= 1'b0;
         ChanErr    <= 1'b0;
      end else begin
         fen_old    <= FilterEN_In;
         SweepAbort <= 1'b0;
         ChanErr    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (chan_bad) begin
                     ChanErr <= 1'b1;
                  end else begin
                     chan_q <= Chan_In;
                     mode_q <= Mode_In;
                     tap    <= TAP_MAX;
                     state  <= (Mode_In == MODE_CLR) ? S_CLR : S_RD;
                  end
               end
            end
            S_RD, S_PRES, S_CLR: begin
               if (!FilterEN_In) begin
                  state      <= S_IDLE;
                  tap        <= TAP_MAX;
                  SweepAbort <= 1'b1;
               end else if (state == S_RD) begin
                  state <= S_PRES;
               end else if (advance) begin
                  if (tap == '0) begin
                     state <= S_DONE;
                  end else begin
                     tap   <= tap - 1'b1;
                     state <= (state == S_CLR) ? S_CLR : S_RD;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               tap   <= TAP_MAX;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_anc_coef_bank_ctrl.sv
module tb_anc_coef_bank_ctrl;

   localparam int COEF_W   = 11;
   localparam int TAPS     = 120;
   localparam int ADDR_W   = 7;
   localparam int CHANNELS = 2;
   localparam int CH_W     = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              fen = 1'b0;
   logic [CH_W-1:0]   chan = '0;
   logic [1:0]        mode = '0;
   logic [COEF_W-1:0] wz = '0;
   logic              wz_valid = 1'b0;
   logic [COEF_W-1:0] WzOut;
   logic              WzOut_Valid;
   logic [ADDR_W-1:0] TapIdx;
   logic              Busy;
   logic              FiltComplete;
   logic              SweepAbort;
   logic              ChanErr;

   always #5 clk = ~clk;

   anc_coef_bank_ctrl #(
      .COEF_W(COEF_W), .TAPS(TAPS), .ADDR_W(ADDR_W),
      .CHANNELS(CHANNELS), .CH_W(CH_W)
   ) dut (
      .Clk_100M(clk),
      .Reset_n(rst_n),
      .FilterEN_In(fen),
      .Chan_In(chan),
      .Mode_In(mode),
      .Wz_In(wz),
      .WzIn_Valid(wz_valid),
      .WzOut(WzOut),
      .WzOut_Valid(WzOut_Valid),
      .TapIdx(TapIdx),
      .Busy(Busy),
      .FiltComplete(FiltComplete),
      .SweepAbort(SweepAbort),
      .ChanErr(ChanErr)
   );

   int checks = 0;
   int errors = 0;
   logic [COEF_W-1:0] model [CHANNELS][TAPS];

   typedef struct {
      logic [CH_W-1:0] chan;
      logic [1:0]      mode;
      int              mul;
      int              add;
      int              exp_done;
      int              exp_pres;
      logic            exp_err;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start a sweep and follow it to completion. k counts cycles from the
   // first cycle in RD/CLR, so FiltComplete lands at k = 2*TAPS (update,
   // read-only) or TAPS (clear).
   task automatic run_sweep(input logic [CH_W-1:0] c, input logic [1:0] m,
                            input int mul, input int add, input int stall_tap,
                            input int exp_done, input int exp_pres,
                            input logic exp_err, input string tag);
      int got, npres, bad, tap_exp, stall_left, aborts;
      logic [COEF_W-1:0] stall_val, v;
      got = -1; npres = 0; bad = 0; tap_exp = TAPS - 1; stall_left = 0; aborts = 0;
      stall_val = '0;
      fen = 1'b0; wz_valid = 1'b1; wz = 11'h155;
      tick();
      chan = c; mode = m; fen = 1'b1;
      tick();
      if (exp_err) begin
         chk({tag, " chan_err"}, 32'(ChanErr), 32'd1);
         chk({tag, " busy stays low"}, 32'(Busy), 32'd0);
         tick();
         chk({tag, " chan_err single pulse"}, 32'(ChanErr), 32'd0);
         chk({tag, " busy still low"}, 32'(Busy), 32'd0);
         fen = 1'b0; wz_valid = 1'b0;
         return;
      end
      chk({tag, " busy at entry"}, 32'(Busy), 32'd1);
      for (int k = 0; k < 1000; k++) begin
         if (SweepAbort) aborts++;
         if (FiltComplete) begin
            got = k;
            break;
         end
         if (!WzOut_Valid) begin
            if (WzOut !== '0 || TapIdx !== '0) bad++;
         end else if (stall_left > 0) begin
            if (TapIdx !== ADDR_W'(stall_tap) || WzOut !== stall_val) bad++;
            stall_left--;
            if (stall_left == 0) wz_valid = 1'b1;
         end else begin
            if (tap_exp < 0) bad++;
            else if (TapIdx !== ADDR_W'(tap_exp) || WzOut !== model[c][tap_exp]) bad++;
            npres++;
            if (m == 2'b00 && tap_exp >= 0) begin
               v = COEF_W'(mul * tap_exp + add);
               if (tap_exp == stall_tap) begin
                  stall_val  = model[c][tap_exp];
                  stall_left = 5;
                  wz_valid   = 1'b0;
               end
               wz = v;
               model[c][tap_exp] = v;
            end
            tap_exp--;
         end
         tick();
      end
      chk({tag, " completion cycle"}, 32'(got), 32'(exp_done));
      chk({tag, " presentations"}, 32'(npres), 32'(exp_pres));
      chk({tag, " bad data/tap cycles"}, 32'(bad), 32'd0);
      chk({tag, " no abort pulse"}, 32'(aborts), 32'd0);
      if (got >= 0) begin
         tick();
         chk({tag, " complete single pulse"}, 32'(FiltComplete), 32'd0);
         chk({tag, " idle after done"}, 32'(Busy), 32'd0);
      end
      if (m == 2'b10)
         for (int t = 0; t < TAPS; t++) model[c][t] = '0;
      fen = 1'b0; wz_valid = 1'b0;
   endtask

   initial begin
      int tap_exp;
      logic reached;
      logic [COEF_W-1:0] v;

      vecs[0]  = '{2'd0, 2'b10,  0, 0, 120,   0, 1'b0};
      vecs[1]  = '{2'd1, 2'b10,  0, 0, 120,   0, 1'b0};
      vecs[2]  = '{2'd0, 2'b01,  0, 0, 240, 120, 1'b0};
      vecs[3]  = '{2'd1, 2'b00,  3, 0, 240, 120, 1'b0};
      vecs[4]  = '{2'd1, 2'b11,  0, 0, 240, 120, 1'b0};
      vecs[5]  = '{2'd0, 2'b01,  0, 0, 240, 120, 1'b0};
      vecs[6]  = '{2'd2, 2'b00,  0, 0,   0,   0, 1'b1};
      vecs[7]  = '{2'd3, 2'b10,  0, 0,   0,   0, 1'b1};
      vecs[8]  = '{2'd0, 2'b00, -2, 0, 240, 120, 1'b0};
      vecs[9]  = '{2'd0, 2'b11,  0, 0, 240, 120, 1'b0};
      vecs[10] = '{2'd1, 2'b01,  0, 0, 240, 120, 1'b0};

      #12;
      chk("reset outputs", {9'd0, WzOut, WzOut_Valid, TapIdx, Busy, FiltComplete, SweepAbort, ChanErr}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 11; i++)
         run_sweep(vecs[i].chan, vecs[i].mode, vecs[i].mul, vecs[i].add, -1,
                   vecs[i].exp_done, vecs[i].exp_pres, vecs[i].exp_err,
                   $sformatf("vec%0d", i));

      // WzIn_Valid withheld for 5 cycles at tap 60 of an update sweep.
      run_sweep(2'd1, 2'b00, 3, 1, 60, 245, 120, 1'b0, "stall upd ch1");
      run_sweep(2'd1, 2'b01, 0, 0, -1, 240, 120, 1'b0, "stall readback ch1");

      // Enable dropped while tap 50 is being read: 119..51 written, 50..0 kept.
      fen = 1'b0; wz_valid = 1'b1;
      tick();
      chan = 2'd1; mode = 2'b00; fen = 1'b1;
      tick();
      tap_exp = TAPS - 1; reached = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         if (WzOut_Valid) begin
            v = COEF_W'(7 * tap_exp - 100);
            wz = v;
            model[1][tap_exp] = v;
            if (tap_exp == 51) begin
               reached = 1'b1;
               tick();
               break;
            end
            tap_exp--;
         end
         tick();
      end
      chk("abort reached tap 51", 32'(reached), 32'd1);
      chk("abort issued during read", {30'd0, Busy, WzOut_Valid}, 32'd2);
      fen = 1'b0;
      tick();
      chk("abort pulse", 32'(SweepAbort), 32'd1);
      chk("abort busy low", 32'(Busy), 32'd0);
      chk("abort no complete", 32'(FiltComplete), 32'd0);
      tick();
      chk("abort single pulse", 32'(SweepAbort), 32'd0);
      wz_valid = 1'b0;
      run_sweep(2'd1, 2'b01, 0, 0, -1, 240, 120, 1'b0, "abort readback ch1");

      // Asynchronous reset between edges in the middle of a read-only sweep.
      fen = 1'b0;
      tick();
      chan = 2'd0; mode = 2'b01; fen = 1'b1;
      tick();
      repeat (9) tick();
      chk("pre-reset tap", 32'(TapIdx), 32'd115);
      chk("pre-reset data", 32'(WzOut), 32'(model[0][115]));
      #2;
      rst_n = 1'b0;
      #1;
      chk("async reset outputs", {9'd0, WzOut, WzOut_Valid, TapIdx, Busy, FiltComplete, SweepAbort, ChanErr}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      fen = 1'b0;
      run_sweep(2'd0, 2'b01, 0, 0, -1, 240, 120, 1'b0, "post-reset ro ch0");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
